// File: rtl/sort_pkt_checker_pkg.sv
// Shared types and constants for the sorted-packet stream checker.
// Imported by the checker top and its backpressure LFSR.
package sort_pkt_checker_pkg;

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    localparam int ERR_ORDER    = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_NO_EOP   = 2;
    localparam int ERR_ORPHAN   = 3;

    // x^16+x^14+x^13+x^11+1 on a right-shifting register: bits 0,2,3,5
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random backpressure.
// Holds its state while disabled.
module lfsr16
    import sort_pkt_checker_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            q <= SEED;
        end else if (en_i) begin
            q <= {^(q & LFSR_TAP_MASK), q[15:1]};
        end
    end

    assign state_o = q;

endmodule

// File: rtl/sort_pkt_checker.sv
// Avalon-ST sink checking framing, length and sort order of packets,
// with per-packet status, running counts and optional backpressure.
module sort_pkt_checker
    import sort_pkt_checker_pkg::*;
#(
    parameter int          DWIDTH      = 8,
    parameter int          MAX_PKT_LEN = 16,
    parameter int          CNT_WIDTH   = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         AWIDTH      = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 clear_i,
    input  logic                 bp_en_i,
    input  logic [DWIDTH-1:0]    snk_data_i,
    input  logic                 snk_startofpacket_i,
    input  logic                 snk_endofpacket_i,
    input  logic                 snk_valid_i,
    output logic                 snk_ready_o,
    output logic                 pkt_done_o,
    output logic [AWIDTH-1:0]    pkt_len_o,
    output logic [3:0]           pkt_err_o,
    output logic [CNT_WIDTH-1:0] pkt_cnt_o,
    output logic [CNT_WIDTH-1:0] bad_cnt_o,
    output logic                 err_sticky_o
);

    localparam logic [AWIDTH-1:0] LEN_MAX = AWIDTH'(MAX_PKT_LEN);
    localparam logic [AWIDTH-1:0] LEN_ONE = AWIDTH'(1);

    state_t              state_q, state_d;
    logic [DWIDTH-1:0]   prev_q, prev_d;
    logic [AWIDTH-1:0]   len_q, len_d;
    logic [2:0]          err_q, err_d;
    logic                pend_q, pend_d;
    logic                ready_q;
    logic                acc;
    logic                rep_v;
    logic [AWIDTH-1:0]   rep_len;
    logic [3:0]          rep_err;
    logic [15:0]         lfsr;
    logic                unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .en_i     (bp_en_i),
        .state_o  (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:1];
    assign snk_ready_o = ready_q;
    assign acc         = snk_valid_i & ready_q;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        len_d   = len_q;
        err_d   = err_q;
        pend_d  = 1'b0;
        rep_v   = 1'b0;
        rep_len = '0;
        rep_err = '0;
        if (pend_q) begin
            rep_v   = 1'b1;
            rep_len = LEN_ONE;
        end else if (acc) begin
            if (snk_startofpacket_i) begin
                if (state_q == IN_PKT) begin
                    rep_v   = 1'b1;
                    rep_len = len_q;
                    rep_err = {1'b0, err_q};
                    rep_err[ERR_NO_EOP] = 1'b1;
                end
                prev_d = snk_data_i;
                len_d  = LEN_ONE;
                err_d  = '0;
                if (snk_endofpacket_i) begin
                    state_d = IDLE;
                    if (state_q == IN_PKT) begin
                        pend_d = 1'b1;
                    end else begin
                        rep_v   = 1'b1;
                        rep_len = LEN_ONE;
                    end
                end else begin
                    state_d = IN_PKT;
                end
            end else if (state_q == IDLE) begin
                rep_v = 1'b1;
                rep_err[ERR_ORPHAN] = 1'b1;
            end else begin
                prev_d = snk_data_i;
                if (snk_data_i < prev_q) begin
                    err_d[ERR_ORDER] = 1'b1;
                end
                if (len_q == LEN_MAX) begin
                    err_d[ERR_OVERFLOW] = 1'b1;
                end else begin
                    len_d = len_q + 1'b1;
                end
                if (snk_endofpacket_i) begin
                    rep_v   = 1'b1;
                    rep_len = len_d;
                    rep_err = {1'b0, err_d};
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            len_q      <= '0;
            err_q      <= '0;
            pend_q     <= 1'b0;
            ready_q    <= 1'b0;
            pkt_done_o <= 1'b0;
            pkt_len_o  <= '0;
            pkt_err_o  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            len_q      <= len_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            // stall one beat so the deferred single-word report has its own cycle
            ready_q    <= (~bp_en_i | lfsr[0]) & ~pend_d;
            pkt_done_o <= rep_v;
            if (rep_v) begin
                pkt_len_o <= rep_len;
                pkt_err_o <= rep_err;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pkt_cnt_o    <= '0;
            bad_cnt_o    <= '0;
            err_sticky_o <= 1'b0;
        end else if (clear_i) begin
            pkt_cnt_o    <= '0;
            bad_cnt_o    <= '0;
            err_sticky_o <= 1'b0;
        end else if (rep_v) begin
            pkt_cnt_o <= pkt_cnt_o + 1'b1;
            if (|rep_err) begin
                bad_cnt_o    <= bad_cnt_o + 1'b1;
                err_sticky_o <= 1'b1;
            end
        end
    end

endmodule
